// File: rtl/kinase_ctrl_sequencer_pkg.sv
// Shared definitions for the kinase chip control sequencer: FSM states,
// pump phase tables and pump-select encodings.
package kinase_ctrl_sequencer_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_SETTLE = 3'd1;
   localparam state_t S_PUMP   = 3'd2;
   localparam state_t S_DWELL  = 3'd3;
   localparam state_t S_DONE   = 3'd4;

   localparam logic [1:0] PSEL_NONE = 2'b00;
   localparam logic [1:0] PSEL_A    = 2'b01;
   localparam logic [1:0] PSEL_B    = 2'b10;
   localparam logic [1:0] PSEL_BOTH = 2'b11;

   // Element [0] is the first phase of a stroke.
   localparam logic [5:0][2:0] PUMP_A_SEQ = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
   localparam logic [1:0][1:0] PUMP_B_SEQ = {2'b01, 2'b10};

endpackage

// File: rtl/kinase_ctrl_sequencer_if.sv
// Step-command handshake between a host controller and the sequencer.
interface kinase_ctrl_sequencer_if #(
   parameter int DWELL_W = 16
) ();
   logic               cmd_valid;
   logic               cmd_ready;
   logic [12:0]        cmd_valves;
   logic [3:0]         cmd_select;
   logic [1:0]         cmd_pump;
   logic [7:0]         cmd_strokes;
   logic [DWELL_W-1:0] cmd_dwell;

   modport master (
      output cmd_valid, cmd_valves, cmd_select, cmd_pump, cmd_strokes, cmd_dwell,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_valves, cmd_select, cmd_pump, cmd_strokes, cmd_dwell,
      output cmd_ready
   );
endinterface

// File: rtl/kinase_pump_phaser.sv
// Peristaltic pump phase generator: steps both pump tables while enabled and
// flags the last cycle of the requested number of strokes.
module kinase_pump_phaser #(
   parameter int PHASE_CYC = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] strokes,
   output logic [2:0] pump_a,
   output logic [1:0] pump_b,
   output logic       strokes_done
);
   import kinase_ctrl_sequencer_pkg::*;

   localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYC - 1);

   logic [PW-1:0] phase_cnt;
   logic [2:0]    phase_idx;
   logic [7:0]    left;
   logic          stroke_end;

   // While disabled the counters idle at zero and track the stroke count so
   // the first enabled cycle starts a fresh stroke.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         phase_cnt <= '0;
         phase_idx <= '0;
         left      <= strokes;
      end else if (phase_cnt == PHASE_LAST) begin
         phase_cnt <= '0;
         if (phase_idx == 3'd5) begin
            phase_idx <= '0;
            left      <= left - 8'd1;
         end else begin
            phase_idx <= phase_idx + 3'd1;
         end
      end else begin
         phase_cnt <= phase_cnt + PW'(1);
      end
   end

   assign stroke_end   = (phase_cnt == PHASE_LAST) && (phase_idx == 3'd5);
   assign strokes_done = enable && stroke_end && (left == 8'd1);
   assign pump_a       = enable ? PUMP_A_SEQ[phase_idx] : '0;
   assign pump_b       = enable ? PUMP_B_SEQ[phase_idx[0]] : '0;

endmodule

// File: rtl/kinase_ctrl_sequencer.sv
// Step sequencer for the kinase chip: latches a valve/pump command, settles the
// valves, runs the pumps for the requested strokes, dwells, then reports done.
module kinase_ctrl_sequencer #(
   parameter int SETTLE_CYC = 4,
   parameter int PHASE_CYC  = 100,
   parameter int DWELL_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   kinase_ctrl_sequencer_if.slave  cmd,
   input  logic                    abort,
   output logic [12:0]             ctrl_a,
   output logic [3:0]              ctrl_s,
   output logic [2:0]              pump_a,
   output logic [1:0]              pump_b,
   output logic                    busy,
   output logic                    step_done,
   output logic                    aborted
);
   import kinase_ctrl_sequencer_pkg::*;

   localparam int SW    = $clog2(SETTLE_CYC + 1);
   localparam int CNT_W = (DWELL_W > SW) ? DWELL_W : SW;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         pump_r;
   logic [7:0]         strokes_r;
   logic [DWELL_W-1:0] dwell_r;
   logic [CNT_W-1:0]   dwell_last;
   logic               pump_go;
   logic               pump_en;
   logic               strokes_done;
   logic [2:0]         ph_a;
   logic [1:0]         ph_b;
   state_t             after_pump;

   assign busy          = (state != S_IDLE);
   assign cmd.cmd_ready = (state == S_IDLE) && !abort;
   assign pump_go       = (pump_r != PSEL_NONE) && (strokes_r != 8'd0);
   assign dwell_last    = CNT_W'(dwell_r) - CNT_W'(1);
   assign after_pump    = (dwell_r == '0) ? S_DONE : S_DWELL;
   assign pump_en       = (state == S_PUMP);

   // step_done and aborted are registered, so each pulse lands the cycle after
   // the FSM event that causes it; abort outranks everything except rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pump_r    <= '0;
         strokes_r <= '0;
         dwell_r   <= '0;
         ctrl_a    <= '0;
         ctrl_s    <= '0;
         step_done <= 1'b0;
         aborted   <= 1'b0;
      end else if (abort) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ctrl_a    <= '0;
         ctrl_s    <= '0;
         step_done <= 1'b0;
         aborted   <= busy;
      end else begin
         step_done <= (state == S_DONE);
         aborted   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd.cmd_valid) begin
                  ctrl_a    <= cmd.cmd_valves;
                  ctrl_s    <= cmd.cmd_select;
                  pump_r    <= cmd.cmd_pump;
                  strokes_r <= cmd.cmd_strokes;
                  dwell_r   <= cmd.cmd_dwell;
                  cnt       <= '0;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= pump_go ? S_PUMP : after_pump;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_PUMP: begin
               if (strokes_done) state <= after_pump;
            end
            S_DWELL: begin
               if (cnt == dwell_last) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   kinase_pump_phaser #(
      .PHASE_CYC (PHASE_CYC)
   ) u_phaser (
      .clk          (clk),
      .rst          (rst),
      .enable       (pump_en),
      .strokes      (strokes_r),
      .pump_a       (ph_a),
      .pump_b       (ph_b),
      .strokes_done (strokes_done)
   );

   assign pump_a = (pump_r == PSEL_A || pump_r == PSEL_BOTH) ? ph_a : '0;
   assign pump_b = (pump_r == PSEL_B || pump_r == PSEL_BOTH) ? ph_b : '0;

endmodule

// File: tb/tb_kinase_ctrl_sequencer.sv
// Scoreboard bench for kinase_ctrl_sequencer: stimulus queues expected busy-cycle
// traces, completion/abort pulses and idle snapshots; a monitor process checks them.
module tb_kinase_ctrl_sequencer;
   localparam int SETTLE = 4;
   localparam int PH     = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic [12:0] ctrl_a;
   logic [3:0]  ctrl_s;
   logic [2:0]  pump_a;
   logic [1:0]  pump_b;
   logic        busy;
   logic        step_done;
   logic        aborted;

   kinase_ctrl_sequencer_if #(.DWELL_W(16)) bus ();

   kinase_ctrl_sequencer #(
      .SETTLE_CYC (SETTLE),
      .PHASE_CYC  (PH),
      .DWELL_W    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (bus),
      .abort     (abort),
      .ctrl_a    (ctrl_a),
      .ctrl_s    (ctrl_s),
      .pump_a    (pump_a),
      .pump_b    (pump_b),
      .busy      (busy),
      .step_done (step_done),
      .aborted   (aborted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [12:0] ca; logic [3:0] cs; logic [2:0] pa; logic [1:0] pb; } tr_t;
   typedef struct { logic sd; logic ab; int c; logic [12:0] ca; logic [3:0] cs; } ev_t;
   typedef struct { int c; logic [12:0] ca; logic [3:0] cs; } sn_t;

   tr_t trq[$];
   ev_t evq[$];
   sn_t snq[$];

   int vectors     = 0;
   int miscompares = 0;

   logic [17:0] a_seq;
   logic [3:0]  b_seq;
   int          tx;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic monitor();
      tr_t t;
      ev_t e;
      sn_t s;
      forever begin
         @(negedge clk);
         if (busy) begin
            if (trq.size() == 0) chk("busy_extra", 64'(busy), 64'd0);
            else begin
               t = trq.pop_front();
               chk("trace", 64'({ctrl_a, ctrl_s, pump_a, pump_b}), 64'({t.ca, t.cs, t.pa, t.pb}));
            end
         end
         if (step_done || aborted) begin
            if (evq.size() == 0) chk("pulse_extra", 64'({step_done, aborted}), 64'd0);
            else begin
               e = evq.pop_front();
               chk("pulse", 64'({step_done, aborted, cyc, ctrl_a, ctrl_s, pump_a, pump_b, busy, bus.cmd_ready}),
                   64'({e.sd, e.ab, e.c, e.ca, e.cs, 3'b000, 2'b00, 1'b0, 1'b1}));
            end
         end
         while (snq.size() > 0 && snq[0].c <= cyc) begin
            s = snq.pop_front();
            chk("idle_snap", 64'({cyc, ctrl_a, ctrl_s, pump_a, pump_b, busy, bus.cmd_ready, step_done, aborted}),
                64'({s.c, s.ca, s.cs, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}));
         end
      end
   endtask

   task automatic push_tr(input logic [12:0] ca, input logic [3:0] cs, input logic [2:0] pa, input logic [1:0] pb);
      tr_t t;
      t.ca = ca; t.cs = cs; t.pa = pa; t.pb = pb;
      trq.push_back(t);
   endtask

   task automatic push_ev(input logic sd, input logic ab, input int c, input logic [12:0] ca, input logic [3:0] cs);
      ev_t e;
      e.sd = sd; e.ab = ab; e.c = c; e.ca = ca; e.cs = cs;
      evq.push_back(e);
   endtask

   task automatic push_sn(input int c, input logic [12:0] ca, input logic [3:0] cs);
      sn_t s;
      s.c = c; s.ca = ca; s.cs = cs;
      snq.push_back(s);
   endtask

   task automatic next_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step(input logic [12:0] v, input logic [3:0] s, input logic [1:0] p,
                       input logic [7:0] n, input logic [15:0] d, output int t0);
      int np;
      bus.cmd_valves  = v;
      bus.cmd_select  = s;
      bus.cmd_pump    = p;
      bus.cmd_strokes = n;
      bus.cmd_dwell   = d;
      bus.cmd_valid   = 1'b1;
      next_cyc(1);
      bus.cmd_valid = 1'b0;
      t0 = cyc;
      np = 0;
      repeat (SETTLE) push_tr(v, s, 3'b000, 2'b00);
      if (p != 2'b00 && n != 8'd0) begin
         for (int k = 0; k < int'(n); k++)
            for (int ph = 0; ph < 6; ph++)
               repeat (PH) push_tr(v, s, p[0] ? a_seq[ph*3 +: 3] : 3'b000,
                                   p[1] ? b_seq[(ph % 2)*2 +: 2] : 2'b00);
         np = 6 * PH * int'(n);
      end
      repeat (int'(d)) push_tr(v, s, 3'b000, 2'b00);
      push_tr(v, s, 3'b000, 2'b00);
      push_ev(1'b1, 1'b0, t0 + SETTLE + np + int'(d) + 1, v, s);
   endtask

   task automatic drain();
      int n = 0;
      while ((trq.size() + evq.size() + snq.size()) > 0 && n < 3000) begin
         next_cyc(1);
         n++;
      end
      if (n >= 3000) begin
         chk("drain_timeout", 64'(trq.size() + evq.size() + snq.size()), 64'd0);
         trq.delete();
         evq.delete();
         snq.delete();
      end
      next_cyc(2);
   endtask

   initial begin
      a_seq = {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
      b_seq = {2'b01, 2'b10};
      rst = 1'b1;
      abort = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_valves = '0;
      bus.cmd_select = '0;
      bus.cmd_pump = '0;
      bus.cmd_strokes = '0;
      bus.cmd_dwell = '0;
      fork
         monitor();
      join_none
      next_cyc(3);
      rst = 1'b0;
      push_sn(cyc, 13'h0, 4'h0);
      drain();

      // valve-only step, then outputs hold through idle
      step(13'h1A5, 4'h3, 2'b00, 8'd5, 16'd10, tx);
      drain();
      push_sn(cyc + 2, 13'h1A5, 4'h3);
      drain();

      // abort together with cmd_valid in idle: no transfer, no pulse, ctrl cleared
      bus.cmd_valves = 13'h0FF;
      bus.cmd_select = 4'hC;
      bus.cmd_pump = 2'b01;
      bus.cmd_strokes = 8'd1;
      bus.cmd_dwell = 16'd1;
      bus.cmd_valid = 1'b1;
      abort = 1'b1;
      next_cyc(1);
      bus.cmd_valid = 1'b0;
      abort = 1'b0;
      push_sn(cyc, 13'h0, 4'h0);
      drain();

      step(13'h0F0, 4'hA, 2'b01, 8'd2, 16'd2, tx);
      drain();
      step(13'h1FFF, 4'hF, 2'b11, 8'd1, 16'd0, tx);
      drain();
      step(13'h0001, 4'h1, 2'b10, 8'd0, 16'd0, tx);
      drain();

      // abort during pump_a phase index 3 (011)
      step(13'h155, 4'h5, 2'b01, 8'd2, 16'd4, tx);
      next_cyc(13);
      abort = 1'b1;
      next_cyc(1);
      abort = 1'b0;
      trq.delete();
      evq.delete();
      push_ev(1'b0, 1'b1, cyc, 13'h0, 4'h0);
      push_sn(cyc + 1, 13'h0, 4'h0);
      drain();
      next_cyc(40);

      // rst during dwell, then a normal step
      step(13'h0AA, 4'h6, 2'b00, 8'd0, 16'd20, tx);
      next_cyc(8);
      rst = 1'b1;
      next_cyc(1);
      rst = 1'b0;
      trq.delete();
      evq.delete();
      push_sn(cyc, 13'h0, 4'h0);
      drain();
      step(13'h123, 4'h9, 2'b01, 8'd1, 16'd3, tx);
      drain();

      next_cyc(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kinase_ctrl_sequencer.md
KINASE_CTRL_SEQUENCER -- requirements
Module: kinase_ctrl_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles valves are held before pumping starts.
REQ-002 Parameter PHASE_CYC, default 100: cycles per pump phase.
REQ-003 Parameter DWELL_W, default 16: width of the dwell field.
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port cmd_valid  input  1  step command offered.
REQ-007 Port cmd_ready  output  1  sequencer can accept a step.
REQ-008 Port cmd_valves  input  13  valve word for ctrl_a (1 = pressurized/closed).
REQ-009 Port cmd_select  input  4  valve word for ctrl_s.
REQ-010 Port cmd_pump  input  2  pump select: 00 none, 01 pump_a, 10 pump_b, 11 both.
REQ-011 Port cmd_strokes  input  8  full pump strokes to run.
REQ-012 Port cmd_dwell  input  DWELL_W  hold cycles after pumping.
REQ-013 Port abort  input  1  immediate stop.
REQ-014 Port ctrl_a  output  13  drives chip pad_ctrl_a.
REQ-015 Port ctrl_s  output  4  drives chip pad_ctrl_s.
REQ-016 Port pump_a  output  3  drives chip pad_pump_a.
REQ-017 Port pump_b  output  2  drives chip pad_pump_b.
REQ-018 Port busy  output  1  high in any state other than IDLE.
REQ-019 Port step_done  output  1  one-cycle pulse at step completion.
REQ-020 Port aborted  output  1  one-cycle pulse when abort takes effect.

Function
REQ-021 States SHALL be IDLE, SETTLE, PUMP, DWELL, DONE.
REQ-022 cmd_ready SHALL be high only in IDLE with abort low; a transfer occurs on cmd_valid and cmd_ready both high.
REQ-023 On transfer, the command fields SHALL be registered, ctrl_a and ctrl_s SHALL take cmd_valves and cmd_select on the next cycle, and the state SHALL go to SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to PUMP; if cmd_pump is 00 or cmd_strokes is 0, it SHALL skip to DWELL.
REQ-025 pump_a SHALL cycle through the 6-phase sequence 100, 110, 010, 011, 001, 101; one stroke is 6 phases.
REQ-026 pump_b SHALL cycle through the 2-phase sequence 10, 01; one stroke is 2 phases, repeated 3 times per pump_a stroke period so both pumps finish together.
REQ-027 Each phase SHALL last PHASE_CYC cycles.
REQ-028 PUMP SHALL end after cmd_strokes strokes (6*PHASE_CYC*cmd_strokes cycles).
REQ-029 On leaving PUMP, pump outputs SHALL return to 000/00.
REQ-030 Unselected pumps SHALL stay 000/00 throughout.
REQ-031 DWELL SHALL last cmd_dwell cycles (0 allowed: zero cycles), then go to DONE.
REQ-032 DONE SHALL last one cycle, assert step_done, and return to IDLE.
REQ-033 ctrl_a and ctrl_s SHALL hold the step values through IDLE until the next transfer.
REQ-034 abort SHALL win over every other event, including a simultaneous transfer.
REQ-035 On abort, next cycle: state IDLE; ctrl_a, ctrl_s, pump_a and pump_b all zero; aborted pulses only if busy was high; step_done is not asserted.
REQ-036 Counters SHALL saturate-free: the phase counter wraps at PHASE_CYC-1, and the stroke counter is 8-bit, loaded from cmd_strokes and decremented to 0.

Reset
REQ-037 On rst: state IDLE; ctrl_a, ctrl_s, pump_a, pump_b, busy, step_done and aborted all 0; cmd_ready 1 in the first cycle after rst deasserts.
REQ-038 rst asserted mid-step SHALL behave as abort, without the aborted pulse.

Structure
REQ-039 A shared package SHALL hold the state enum, the pump_a and pump_b phase tables, and the pump-select encodings.
REQ-040 Pump phase generation SHALL be one sub-module, kinase_pump_phaser, with inputs enable and stroke count, and outputs pump_a, pump_b and strokes_done; the FSM stays in the top level.

Verification
REQ-041 Step: valves=13'h1A5, select=4'h3, pump=00, dwell=10 -> ctrl_a=1A5 and ctrl_s=3 after 1 cycle; step_done exactly 1+4+10+1 cycles after transfer; pumps stay 0.
REQ-042 pump=01, strokes=2, PHASE_CYC=3 -> pump_a shows the 6-phase sequence twice, 3 cycles per phase (36 cycles), then 000; pump_b stays 00.
REQ-043 pump=11, strokes=1 -> pump_b toggles 10/01 six times while pump_a completes one stroke; both end at 0 on the same cycle.
REQ-044 abort in PUMP phase 3 -> next cycle all outputs 0, aborted=1 for 1 cycle, step_done never asserted, cmd_ready=1.
REQ-045 abort and cmd_valid together in IDLE -> no transfer, aborted stays 0, outputs 0.
REQ-046 rst during DWELL -> next cycle all outputs 0, busy=0, then a new step completes normally.
